// File: rtl/ae_pkg.sv
// Shared codes for the autoencoder control path: opcodes, ALU/destination selects,
// FSM states and the decoder result types used by the CU and the top level alike.
package ae_pkg;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_MUL  = 4'h3;
   localparam logic [3:0] OP_MAC  = 4'h4;
   localparam logic [3:0] OP_RELU = 4'h5;
   localparam logic [3:0] OP_SIG  = 4'h6;
   localparam logic [3:0] OP_DSIG = 4'h7;
   localparam logic [3:0] OP_MOV  = 4'h8;
   localparam logic [3:0] OP_LOOP = 4'h9;
   localparam logic [3:0] OP_JNZ  = 4'hA;
   localparam logic [3:0] OP_HALT = 4'hF;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_MUL = 2'b10,
      ALU_MAC = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      DEST_RAW  = 2'b00,
      DEST_SIG  = 2'b01,
      DEST_RELU = 2'b10,
      DEST_DSIG = 2'b11
   } dest_sel_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_WB     = 3'd4,
      ST_DONE   = 3'd5
   } state_e;

   // Instruction class; illegal opcodes are a class of their own.
   typedef enum logic [2:0] {
      CLS_NOP  = 3'd0,
      CLS_COMP = 3'd1,
      CLS_LOOP = 3'd2,
      CLS_JNZ  = 3'd3,
      CLS_HALT = 3'd4,
      CLS_ILL  = 3'd5
   } op_class_e;

   typedef struct packed {
      alu_op_e   alu_op;
      logic      op2_zero;
      dest_sel_e dest_sel;
   } ctrl_t;

   typedef struct packed {
      op_class_e cls;
      ctrl_t     ctrl;
   } dec_t;

endpackage

// File: rtl/ae_decode.sv
// Opcode decoder: maps an opcode to its class and the ALU/destination controls.
// Purely combinational.
module ae_decode
   import ae_pkg::*;
#(
   parameter int OPC_W = 4
) (
   input  logic [OPC_W-1:0] opc,
   output dec_t             dec
);

   always_comb begin
      // NOTE: every field gets a default first so no path through the case leaves
      // an output unassigned, which would otherwise infer a latch.
      dec.cls           = CLS_ILL;
      dec.ctrl.alu_op   = ALU_ADD;
      dec.ctrl.op2_zero = 1'b0;
      dec.ctrl.dest_sel = DEST_RAW;
      case (opc)
         OPC_W'(OP_NOP):  dec.cls = CLS_NOP;
         OPC_W'(OP_LOOP): dec.cls = CLS_LOOP;
         OPC_W'(OP_JNZ):  dec.cls = CLS_JNZ;
         OPC_W'(OP_HALT): dec.cls = CLS_HALT;
         OPC_W'(OP_ADD):  dec.cls = CLS_COMP;
         OPC_W'(OP_SUB): begin
            dec.cls         = CLS_COMP;
            dec.ctrl.alu_op = ALU_SUB;
         end
         OPC_W'(OP_MUL): begin
            dec.cls         = CLS_COMP;
            dec.ctrl.alu_op = ALU_MUL;
         end
         OPC_W'(OP_MAC): begin
            dec.cls         = CLS_COMP;
            dec.ctrl.alu_op = ALU_MAC;
         end
         OPC_W'(OP_RELU): begin
            dec.cls           = CLS_COMP;
            dec.ctrl.dest_sel = DEST_RELU;
         end
         OPC_W'(OP_SIG): begin
            dec.cls           = CLS_COMP;
            dec.ctrl.dest_sel = DEST_SIG;
         end
         OPC_W'(OP_DSIG): begin
            dec.cls           = CLS_COMP;
            dec.ctrl.dest_sel = DEST_DSIG;
         end
         OPC_W'(OP_MOV): begin
            dec.cls           = CLS_COMP;
            dec.ctrl.op2_zero = 1'b1;
         end
         default: dec.cls = CLS_ILL;
      endcase
   end

endmodule

// File: rtl/ae_sequencer.sv
// Fetch/decode/execute sequencer for the autoencoder datapath: PC, operand register,
// loop counter, control FSM, start/busy/done handshake, abort and error reporting.
module ae_sequencer
   import ae_pkg::*;
#(
   parameter int INSTR_W = 16,
   parameter int OPC_W   = 4,
   parameter int FIELD_W = 4,
   parameter int PC_W    = 8,
   parameter int LOOP_W  = 8
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               start,
   input  logic               abort,
   output logic               busy,
   output logic               done,
   output logic               error,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_data,
   output logic [FIELD_W-1:0] rf_rd_addr1,
   output logic [FIELD_W-1:0] rf_rd_addr2,
   output logic [FIELD_W-1:0] rf_wr_addr,
   output logic               rf_we,
   output logic               alu_en,
   output logic [1:0]         alu_op,
   output logic               op2_zero,
   output logic [1:0]         dest_sel
);

   localparam int OPND_W = 3 * FIELD_W;

   state_e              state, state_d;
   logic [PC_W-1:0]     pc, pc_d;
   logic [OPND_W-1:0]   ir, ir_d;
   ctrl_t               ctrl_q, ctrl_d;
   logic [LOOP_W-1:0]   loop_cnt, loop_d;
   logic                error_q, error_d;
   logic                abort_pend, abort_d;
   logic                rf_we_q;
   logic                advance;
   logic                exec_phase;
   dec_t                fdec;

   // The opcode is decoded straight off the memory word; only next-state logic and
   // registers consume it, so no output sees imem_data combinationally.
   ae_decode #(.OPC_W(OPC_W)) u_decode (
      .opc (imem_data[INSTR_W-1 -: OPC_W]),
      .dec (fdec)
   );

   always_comb begin
      state_d = state;
      pc_d    = pc;
      ir_d    = ir;
      ctrl_d  = ctrl_q;
      loop_d  = loop_cnt;
      error_d = error_q;
      abort_d = abort_pend | abort;
      advance = 1'b0;
      case (state)
         ST_IDLE: begin
            abort_d = 1'b0;
            if (start) begin
               pc_d    = '0;
               error_d = 1'b0;
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: state_d = (abort_pend || abort) ? ST_DONE : ST_DECODE;
         ST_DECODE: begin
            ir_d   = imem_data[OPND_W-1:0];
            ctrl_d = fdec.ctrl;
            case (fdec.cls)
               CLS_COMP: state_d = ST_EXEC;
               CLS_HALT: state_d = ST_DONE;
               CLS_ILL: begin
                  error_d = 1'b1;
                  state_d = ST_DONE;
               end
               CLS_LOOP: begin
                  loop_d  = imem_data[LOOP_W-1:0];
                  advance = 1'b1;
               end
               CLS_JNZ: begin
                  if (loop_cnt != '0) begin
                     loop_d  = loop_cnt - 1'b1;
                     pc_d    = imem_data[PC_W-1:0];
                     state_d = ST_FETCH;
                  end else begin
                     advance = 1'b1;
                  end
               end
               default: advance = 1'b1;
            endcase
         end
         ST_EXEC: state_d = ST_WB;
         ST_WB:   advance = 1'b1;
         ST_DONE: begin
            abort_d = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Sequential advance; the PC never wraps, running off the end is an error.
      if (advance) begin
         if (&pc) begin
            error_d = 1'b1;
            state_d = ST_DONE;
         end else begin
            pc_d    = pc + 1'b1;
            state_d = ST_FETCH;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples the
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         pc         <= '0;
         ir         <= '0;
         ctrl_q     <= '{alu_op: ALU_ADD, op2_zero: 1'b0, dest_sel: DEST_RAW};
         loop_cnt   <= '0;
         error_q    <= 1'b0;
         abort_pend <= 1'b0;
         rf_we_q    <= 1'b0;
      end else begin
         state      <= state_d;
         pc         <= pc_d;
         ir         <= ir_d;
         ctrl_q     <= ctrl_d;
         loop_cnt   <= loop_d;
         error_q    <= error_d;
         abort_pend <= abort_d;
         // Write strobe comes straight from a flop so it cannot glitch on state decode.
         rf_we_q    <= (state_d == ST_WB);
      end
   end

   assign exec_phase  = (state == ST_EXEC) || (state == ST_WB);
   assign busy        = (state != ST_IDLE);
   assign done        = (state == ST_DONE);
   assign error       = error_q;
   assign imem_addr   = pc;
   assign rf_we       = rf_we_q;
   assign alu_en      = exec_phase;
   assign alu_op      = exec_phase ? ctrl_q.alu_op : ALU_ADD;
   assign op2_zero    = exec_phase & ctrl_q.op2_zero;
   assign dest_sel    = exec_phase ? ctrl_q.dest_sel : DEST_RAW;
   assign rf_rd_addr1 = exec_phase ? ir[OPND_W-1 -: FIELD_W] : '0;
   assign rf_rd_addr2 = exec_phase ? ir[2*FIELD_W-1 -: FIELD_W] : '0;
   assign rf_wr_addr  = (state == ST_WB) ? ir[FIELD_W-1:0] : '0;

endmodule

// File: tb/tb_ae_sequencer.sv
// Self-checking bench for ae_sequencer: an instruction-level reference model expands
// each program into the expected per-cycle handshake/control trace.
module tb_ae_sequencer;

   logic        clock = 1'b0;
   logic        reset_n, start, abort;
   logic        busy, done, error, rf_we, alu_en, op2_zero;
   logic [7:0]  imem_addr;
   logic [15:0] imem_data;
   logic [3:0]  rf_rd_addr1, rf_rd_addr2, rf_wr_addr;
   logic [1:0]  alu_op, dest_sel;

   logic [15:0] mem [256];

   typedef enum {P_FETCH, P_DECODE, P_EXEC, P_WB, P_DONE} phase_e;
   typedef struct {
      phase_e     ph;
      logic       err;
      logic [1:0] op;
      logic       z;
      logic [1:0] dsel;
      logic [3:0] rd1, rd2, wr;
   } cyc_t;

   cyc_t  exp_q[$];
   int    n_cmp = 0;
   int    n_fail = 0;
   int    we_seen;
   string cur_test;

   ae_sequencer dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .start       (start),
      .abort       (abort),
      .busy        (busy),
      .done        (done),
      .error       (error),
      .imem_addr   (imem_addr),
      .imem_data   (imem_data),
      .rf_rd_addr1 (rf_rd_addr1),
      .rf_rd_addr2 (rf_rd_addr2),
      .rf_wr_addr  (rf_wr_addr),
      .rf_we       (rf_we),
      .alu_en      (alu_en),
      .alu_op      (alu_op),
      .op2_zero    (op2_zero),
      .dest_sel    (dest_sel)
   );

   always #5 clock = ~clock;

   // Synchronous-read instruction memory, one cycle of latency.
   always @(posedge clock) imem_data <= mem[imem_addr];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic cyc_t blank(input phase_e p, input logic e);
      cyc_t c;
      c.ph = p; c.err = e; c.op = 2'd0; c.z = 1'b0; c.dsel = 2'd0;
      c.rd1 = 4'd0; c.rd2 = 4'd0; c.wr = 4'd0;
      return c;
   endfunction

   // Instruction-level interpretation of the program held in mem.
   task automatic build(input int abort_at);
      int          pc = 0;
      int          lc = 0;
      int          opc;
      logic [15:0] w;
      cyc_t        c;
      exp_q.delete();
      while (exp_q.size() < 4000) begin
         exp_q.push_back(blank(P_FETCH, 1'b0));
         if (abort_at >= 0 && abort_at <= exp_q.size() - 1) begin
            exp_q.push_back(blank(P_DONE, 1'b0));
            return;
         end
         w   = mem[pc];
         opc = int'(w[15:12]);
         exp_q.push_back(blank(P_DECODE, 1'b0));
         if (opc >= 11 && opc <= 14) begin
            exp_q.push_back(blank(P_DONE, 1'b1));
            return;
         end
         if (opc == 15) begin
            exp_q.push_back(blank(P_DONE, 1'b0));
            return;
         end
         if (opc >= 1 && opc <= 8) begin
            c      = blank(P_EXEC, 1'b0);
            c.op   = (opc <= 4) ? 2'(opc - 1) : 2'd0;
            c.z    = (opc == 8);
            c.dsel = (opc == 5) ? 2'd2 : (opc == 6) ? 2'd1 : (opc == 7) ? 2'd3 : 2'd0;
            c.rd1  = w[11:8];
            c.rd2  = w[7:4];
            c.wr   = w[3:0];
            exp_q.push_back(c);
            c.ph = P_WB;
            exp_q.push_back(c);
         end
         if (opc == 10 && lc != 0) begin
            lc--;
            pc = int'(w[7:0]);
            continue;
         end
         if (opc == 9) lc = int'(w[7:0]);
         if (pc == 255) begin
            exp_q.push_back(blank(P_DONE, 1'b1));
            return;
         end
         pc++;
      end
   endtask

   task automatic check_cycle(input int i);
      cyc_t  c;
      string t;
      c = exp_q[i];
      t = $sformatf("%s[%0d]", cur_test, i);
      check({t, ".busy"}, busy, 1);
      check({t, ".done"}, done, c.ph == P_DONE);
      check({t, ".error"}, error, c.err);
      check({t, ".rf_we"}, rf_we, c.ph == P_WB);
      if (c.ph != P_WB) check({t, ".alu_en"}, alu_en, c.ph == P_EXEC);
      if (c.ph == P_EXEC) begin
         check({t, ".rd1"}, rf_rd_addr1, c.rd1);
         check({t, ".rd2"}, rf_rd_addr2, c.rd2);
      end
      if (c.ph == P_EXEC || c.ph == P_WB) begin
         check({t, ".alu_op"}, alu_op, c.op);
         check({t, ".op2_zero"}, op2_zero, c.z);
         check({t, ".dest_sel"}, dest_sel, c.dsel);
      end
      if (c.ph == P_WB) check({t, ".wr"}, rf_wr_addr, c.wr);
      if (rf_we === 1'b1) we_seen++;
   endtask

   task automatic walk(input int first, input int abort_at);
      for (int i = first; i < exp_q.size(); i++) begin
         if (i != first) begin
            @(posedge clock); #1;
         end
         check_cycle(i);
         abort = (i == abort_at);
      end
      abort = 1'b0;
   endtask

   task automatic run(input string name, input int abort_at);
      cur_test = name;
      build(abort_at);
      we_seen = 0;
      @(negedge clock); start = 1'b1;
      @(posedge clock); #1; start = 1'b0;
      walk(0, abort_at);
      @(posedge clock); #1;
      check({name, ".idle_busy"}, busy, 0);
      check({name, ".idle_done"}, done, 0);
      check({name, ".idle_error"}, error, exp_q[exp_q.size() - 1].err);
   endtask

   task automatic clear_mem();
      foreach (mem[i]) mem[i] = 16'h0000;
   endtask

   function automatic int pick_exec(input int nth);
      int seen = 0;
      foreach (exp_q[i]) begin
         if (exp_q[i].ph == P_EXEC) begin
            if (seen == nth) return i;
            seen++;
         end
      end
      return -1;
   endfunction

   task automatic gen_random();
      int n, p, body, opc;
      bit use_loop;
      clear_mem();
      n        = $urandom_range(2, 6);
      use_loop = 1'($urandom_range(0, 1));
      p        = 0;
      if (use_loop) begin
         mem[p] = {4'h9, 4'h0, 8'($urandom_range(0, 3))};
         p++;
      end
      body = p;
      for (int k = 0; k < n; k++) begin
         opc = $urandom_range(1, 8);
         if ($urandom_range(0, 9) == 0) opc = $urandom_range(11, 14);
         mem[p] = {4'(opc), 12'($urandom)};
         p++;
      end
      if (use_loop) begin
         mem[p] = {4'hA, 4'h0, 8'(body)};
         p++;
      end
      mem[p] = 16'hF000;
   endtask

   initial begin
      int ab;
      reset_n = 1'b0;
      start   = 1'b0;
      abort   = 1'b0;
      clear_mem();
      #2;
      check("reset.busy", busy, 0);
      check("reset.done", done, 0);
      check("reset.error", error, 0);
      check("reset.rf_we", rf_we, 0);
      check("reset.alu_en", alu_en, 0);
      check("reset.imem_addr", imem_addr, 0);
      check("reset.ctrl", {alu_op, op2_zero, dest_sel}, 0);
      check("reset.addrs", {rf_rd_addr1, rf_rd_addr2, rf_wr_addr}, 0);
      @(negedge clock); reset_n = 1'b1;

      // Single add followed by HALT.
      mem[0] = 16'h1123; mem[1] = 16'hF000;
      run("add_halt", -1);

      // Destination/operand-zero variants.
      clear_mem();
      mem[0] = 16'h5123; mem[1] = 16'h6456; mem[2] = 16'h7789;
      mem[3] = 16'h8ABC; mem[4] = 16'h2DEF; mem[5] = 16'hF000;
      run("dest_ops", -1);

      // Hardware loop: body executes four times.
      clear_mem();
      mem[0] = 16'h9003; mem[1] = 16'h1123; mem[2] = 16'hA001; mem[3] = 16'hF000;
      run("loop", -1);
      check("loop.we_count", we_seen, 4);

      // Illegal opcode at pc=2; error stays set into IDLE.
      clear_mem();
      mem[0] = 16'h1123; mem[1] = 16'h3456; mem[2] = 16'hC000;
      run("illegal", -1);

      // Restart clears error; start held through DONE restarts from the next IDLE cycle.
      clear_mem();
      mem[0] = 16'h1123; mem[1] = 16'hF000;
      run("restart", -1);
      @(negedge clock); start = 1'b1;
      @(posedge clock); #1; start = 1'b0;
      walk(0, -1);
      start = 1'b1;
      @(posedge clock); #1;
      check("restart.held_idle_busy", busy, 0);
      @(posedge clock); #1;
      start = 1'b0;
      walk(0, -1);
      @(posedge clock); #1;
      check("restart.final_idle", busy, 0);

      // Abort during EXEC of the second instruction: its WB completes, then DONE.
      clear_mem();
      mem[0] = 16'h1123; mem[1] = 16'h3456; mem[2] = 16'h4789; mem[3] = 16'hF000;
      build(-1);
      ab = pick_exec(1);
      run("abort", ab);
      check("abort.we_count", we_seen, 2);

      // Randomized programs, every other one aborted at a random EXEC.
      for (int r = 0; r < 8; r++) begin
         gen_random();
         build(-1);
         ab = -1;
         if (r % 2 == 1) ab = pick_exec($urandom_range(0, 2));
         run($sformatf("rand%0d", r), ab);
      end

      // Reset asserted during WB.
      clear_mem();
      mem[0] = 16'h1123; mem[1] = 16'hF000;
      @(negedge clock); start = 1'b1;
      @(posedge clock); #1; start = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_wb.pre_we", rf_we, 1);
      #2 reset_n = 1'b0;
      #1;
      check("rst_wb.rf_we", rf_we, 0);
      check("rst_wb.busy", busy, 0);
      check("rst_wb.alu_en", alu_en, 0);
      check("rst_wb.done", done, 0);
      @(negedge clock); reset_n = 1'b1;

      // All-NOP program runs off the end of instruction memory.
      clear_mem();
      run("pc_overflow", -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
